// File: rtl/multi_cycle_processor.sv
// multi_cycle_processor: multi-cycle core with 16-bit instructions, 8-entry register file and handshaked instruction/data ports
module multi_cycle_processor #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    input  logic              imem_ack,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic [DATA_W-1:0] result,
    output logic              retire,
    output logic              halted,
    output logic              illegal
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
    state_t state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, dmem_addr_q, dmem_addr_d;
    logic [15:0] ir_q, ir_d;
    logic [DATA_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rdv_q, rdv_d, wb_q, wb_d;
    logic [DATA_W-1:0] dmem_wdata_q, dmem_wdata_d, result_q, result_d, alu;
    logic [DATA_W-1:0] rf_q [8];
    logic [DATA_W-1:0] rf_d [8];
    logic imem_req_q, imem_req_d, dmem_req_q, dmem_req_d, dmem_we_q, dmem_we_d;
    logic retire_q, retire_d, halted_q, halted_d, illegal_q, illegal_d;
    logic [3:0] op;
    logic [2:0] rd;
    logic [DATA_W-1:0] imm3_d;
    logic [ADDR_W-1:0] imm3_a, imm9_a, pc_inc;
    assign op = ir_q[15:12];
    assign rd = ir_q[8:6];
    assign imm3_d = DATA_W'($signed(ir_q[2:0]));
    assign imm3_a = ADDR_W'($signed(ir_q[2:0]));
    assign imm9_a = ADDR_W'($signed(ir_q[8:0]));
    assign pc_inc = pc_q + ADDR_W'(1);
    assign imem_req = imem_req_q;
    assign imem_addr = pc_q;
    assign dmem_req = dmem_req_q;
    assign dmem_we = dmem_we_q;
    assign dmem_addr = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign result = result_q;
    assign retire = retire_q;
    assign halted = halted_q;
    assign illegal = illegal_q;
    // R-type ALU on the operands latched in DECODE
    always_comb begin
        case (ir_q[11:9])
            3'd0: alu = rs1_q + rs2_q;
            3'd1: alu = rs1_q - rs2_q;
            3'd2: alu = rs1_q & rs2_q;
            3'd3: alu = rs1_q | rs2_q;
            3'd4: alu = rs1_q ^ rs2_q;
            3'd5: alu = DATA_W'(rs1_q < rs2_q);
            3'd6: alu = rs1_q << 1;
            default: alu = rs1_q >> 1;
        endcase
    end
    // next-state logic; request/status outputs follow the next state so they are registered
    always_comb begin
        state_d = state_q;
        pc_d = pc_q;
        ir_d = ir_q;
        rs1_d = rs1_q;
        rs2_d = rs2_q;
        rdv_d = rdv_q;
        wb_d = wb_q;
        rf_d = rf_q;
        dmem_addr_d = dmem_addr_q;
        dmem_we_d = dmem_we_q;
        dmem_wdata_d = dmem_wdata_q;
        result_d = result_q;
        illegal_d = illegal_q;
        retire_d = 1'b0;
        case (state_q)
            FETCH: if (imem_req_q && imem_ack) begin
                ir_d = imem_rdata;
                state_d = DECODE;
            end
            DECODE: begin
                rs1_d = rf_q[ir_q[5:3]];
                rs2_d = rf_q[ir_q[2:0]];
                rdv_d = rf_q[rd];
                state_d = EXEC;
            end
            EXEC: case (op)
                4'd0: begin
                    wb_d = alu;
                    state_d = WB;
                end
                4'd1: begin
                    wb_d = rs1_q + imm3_d;
                    state_d = WB;
                end
                4'd2, 4'd3: begin
                    dmem_addr_d = ADDR_W'(rs1_q) + imm3_a;
                    dmem_we_d = op[0];
                    dmem_wdata_d = rdv_q;
                    state_d = MEM;
                end
                4'd4: begin
                    pc_d = (rdv_q == rs1_q) ? pc_q + imm3_a : pc_inc;
                    retire_d = 1'b1;
                    state_d = FETCH;
                end
                4'd5: begin
                    pc_d = pc_q + imm9_a;
                    retire_d = 1'b1;
                    state_d = FETCH;
                end
                4'd6: state_d = HALT;
                default: begin
                    illegal_d = 1'b1;
                    pc_d = pc_inc;
                    retire_d = 1'b1;
                    state_d = FETCH;
                end
            endcase
            MEM: if (dmem_req_q && dmem_ack) begin
                wb_d = dmem_we_q ? wb_q : dmem_rdata;
                pc_d = dmem_we_q ? pc_inc : pc_q;
                retire_d = dmem_we_q;
                state_d = dmem_we_q ? FETCH : WB;
            end
            WB: begin
                if (rd != 3'd0) rf_d[rd] = wb_q;
                result_d = wb_q;
                pc_d = pc_inc;
                retire_d = 1'b1;
                state_d = FETCH;
            end
            default: ;
        endcase
        imem_req_d = state_d == FETCH;
        dmem_req_d = state_d == MEM;
        halted_d = state_d == HALT;
    end
    // state register with synchronous active-low reset; reset drops any outstanding request
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= FETCH;
            pc_q <= '0;
            ir_q <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
            rdv_q <= '0;
            wb_q <= '0;
            rf_q <= '{default: '0};
            dmem_addr_q <= '0;
            dmem_we_q <= 1'b0;
            dmem_wdata_q <= '0;
            result_q <= '0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            retire_q <= 1'b0;
            halted_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            ir_q <= ir_d;
            rs1_q <= rs1_d;
            rs2_q <= rs2_d;
            rdv_q <= rdv_d;
            wb_q <= wb_d;
            rf_q <= rf_d;
            dmem_addr_q <= dmem_addr_d;
            dmem_we_q <= dmem_we_d;
            dmem_wdata_q <= dmem_wdata_d;
            result_q <= result_d;
            imem_req_q <= imem_req_d;
            dmem_req_q <= dmem_req_d;
            retire_q <= retire_d;
            halted_q <= halted_d;
            illegal_q <= illegal_d;
        end
    end
endmodule

// File: doc/multi_cycle_processor.md
MULTI_CYCLE_PROCESSOR -- requirements
Module: multi_cycle_processor

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the width of the datapath, registers and ALU.
REQ-002 The block SHALL have parameter ADDR_W, default 8, meaning the width of the PC and data address.
REQ-003 The block SHALL have these ports, clock and reset first:
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  synchronous reset, active-low.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  ADDR_W  fetch address (equals the PC).
- imem_rdata  in  16  instruction word.
- imem_ack  in  1  fetch complete; imem_rdata is valid this cycle.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  ADDR_W  data address.
- dmem_wdata  out  DATA_W  store data.
- dmem_rdata  in  DATA_W  load data.
- dmem_ack  in  1  data access complete.
- result  out  DATA_W  last value written to the register file.
- retire  out  1  one-cycle pulse per completed instruction.
- halted  out  1  core is in HALT.
- illegal  out  1  sticky flag: an undefined opcode was seen.
REQ-004 Reset SHALL be synchronous and active-low on RST_N, sampled on the CLK rising edge; CLK is the only clock.

Function
REQ-005 The instruction format SHALL be: op[15:12], funct[11:9], rd[8:6], rs1[5:3], rs2/imm3[2:0]; imm3 and imm9[8:0] are sign-extended to DATA_W or ADDR_W as needed.
REQ-006 The register file SHALL hold 8 registers of DATA_W bits; r0 SHALL read as zero, and writes to r0 SHALL be discarded.
REQ-007 The opcodes SHALL be:
- 0: R-type ALU, rd = rs1 op rs2. funct: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt (unsigned), 6 shl1 (shift rs1 left by 1), 7 shr1 (logical shift rs1 right by 1).
- 1: ADDI, rd = rs1 + imm3.
- 2: LOAD, rd = mem[rs1 + imm3].
- 3: STORE, mem[rs1 + imm3] = rd.
- 4: BEQ, if rd == rs1 then PC = PC + imm3.
- 5: JMP, PC = PC + imm9.
- 6: HALT.
- 7-15: illegal; executed as a NOP with illegal set.
REQ-008 The FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-009 FETCH: imem_req = 1 and imem_addr = PC, held until imem_ack; on imem_ack the IR SHALL latch imem_rdata and the FSM SHALL go to DECODE.
REQ-010 DECODE SHALL take 1 cycle, reading rs1/rs2/rd operands into registers, then go to EXEC.
REQ-011 EXEC SHALL take 1 cycle:
- ALU and ADDI go to WB.
- LOAD and STORE go to MEM.
- BEQ and JMP update the PC, pulse retire and go to FETCH.
- HALT goes to HALT with PC unchanged.
- Illegal opcodes set illegal, PC+1, pulse retire, go to FETCH.
REQ-012 MEM: dmem_req = 1 with dmem_addr, dmem_we and dmem_wdata stable until dmem_ack.
- LOAD latches dmem_rdata and goes to WB.
- STORE does PC+1, pulses retire and goes to FETCH.
REQ-013 WB SHALL take 1 cycle: write rd, update result with the written value (even when rd = r0), PC+1, pulse retire, go to FETCH.
REQ-014 Arithmetic SHALL be modulo 2^DATA_W; PC and address arithmetic SHALL be modulo 2^ADDR_W, so the PC wraps from 2^ADDR_W-1 to 0.
REQ-015 A not-taken BEQ SHALL do PC+1; a taken branch with offset 0 SHALL loop on itself.
REQ-016 Latency SHALL be:
- ALU/ADDI: 4 cycles with zero-wait acks.
- LOAD: 5 cycles.
- STORE: 4 cycles.
- BEQ/JMP: 3 cycles.
- Each extra wait cycle on an ack adds 1.
REQ-017 imem_req and dmem_req SHALL never be asserted in the same cycle; acks arriving outside the matching request SHALL be ignored.
REQ-018 HALT SHALL be terminal until reset: halted = 1, no requests, retire = 0.

Reset
REQ-019 While RST_N = 0, at the next edge the block SHALL set:
- PC = 0 and state = FETCH.
- All registers = 0.
- result = 0, retire = 0, halted = 0, illegal = 0.
- imem_req = 0 and dmem_req = 0.
REQ-020 Reset asserted mid-access SHALL drop the outstanding request on the next edge, with no register or PC update from that instruction.
REQ-021 After RST_N rises, imem_req SHALL assert in the first cycle, with imem_addr = 0.

Verification
REQ-022 Program ADDI r1,r0,3; ADDI r2,r0,-1; R-add r3,r1,r2 with zero-wait acks -> result 3, 0xFF, 0x02; retire pulses 4 cycles apart.
REQ-023 STORE r1 to [r0+2] then LOAD r4,[r0+2], with dmem_ack delayed 2 cycles -> dmem_we = 1, addr 2, wdata 3; then result = 3; LOAD takes 7 cycles.
REQ-024 BEQ r1,r1,-2 at PC 5 -> next imem_addr 3; with unequal operands -> next imem_addr 6; PC 0xFF + 1 -> 0x00.
REQ-025 Opcode 0xF at PC 4 -> illegal = 1 and stays set, next fetch at 5; HALT -> halted = 1 and no further imem_req for 20 cycles.
REQ-026 RST_N low during a MEM wait -> dmem_req = 0 next cycle, rd unchanged; after release, imem_addr = 0.
REQ-027 Run the REQ-022 program with DATA_W = 16 and ADDR_W = 10 -> results 3, 0xFFFF, 0x0002.
